// File: rtl/mem_txn_checker.sv
// Bus monitor for the CPU-to-cache data port: counts reads/writes/stalls, checks read data
// against a word-address pattern or a shadow of prior writes, and latches first-error context.
module mem_txn_checker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SHADOW_AW   = 6,
  parameter int CNT_W       = 16,
  parameter int STALL_MAX   = 64,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              clear,
  input  logic              Mem_Write,
  input  logic              Mem_read,
  input  logic              stall,
  input  logic [ADDR_W-1:0] a_data_mem,
  input  logic [DATA_W-1:0] w_data_mem,
  input  logic [DATA_W-1:0] r_data_mem,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_flag,
  output logic              timeout,
  output logic              chk_pass,
  output logic              chk_fail,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [1:0]        state
);
  // state | meaning
  // IDLE  | monitor parked, bus ignored
  // RUN   | commits counted and reads checked
  // HALT  | stopped after an error, waits for clear
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  localparam int RUN_W = $clog2(STALL_MAX + 1);
  localparam int DEPTH = 1 << SHADOW_AW;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_MAX - 1);
  localparam logic [RUN_W-1:0] RUN_TOP  = RUN_W'(STALL_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, err_cnt_q, err_cnt_d;
  logic              err_flag_q, err_flag_d, timeout_q, timeout_d;
  logic              pass_q, pass_d, fail_q, fail_d;
  logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [DATA_W-1:0] fe_data_q, fe_data_d, fe_exp_q, fe_exp_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DATA_W-1:0] shadow_mem [DEPTH];

  logic              active, req_both, stall_cyc, rd_commit, wr_commit;
  logic              rd_mismatch, timeout_evt, in_range;
  logic [ADDR_W-1:0] word_addr;
  logic [SHADOW_AW-1:0] idx;
  logic [DATA_W-1:0] pattern, exp_val, err_exp;
  logic [1:0]        err_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  assign active    = (state_q == RUN) && enable;
  assign word_addr = a_data_mem >> 2;
  assign idx       = a_data_mem[SHADOW_AW+1:2];
  assign in_range  = (word_addr >> SHADOW_AW) == '0;
  assign pattern   = DATA_W'(word_addr);
  assign exp_val   = (mode && in_range && vld_q[idx]) ? shadow_mem[idx] : pattern;

  assign req_both    = active & Mem_read & Mem_Write;
  assign stall_cyc   = active & stall & (Mem_read | Mem_Write);
  assign rd_commit   = active & Mem_read & ~Mem_Write & ~stall;
  assign wr_commit   = active & Mem_Write & ~Mem_read & ~stall;
  assign rd_mismatch = rd_commit && (r_data_mem != exp_val);
  // run_q parks at STALL_MAX, so the timeout fires once per stall episode
  assign timeout_evt = stall_cyc && (run_q == RUN_LAST);
  assign err_inc     = {1'b0, req_both} + {1'b0, timeout_evt} + {1'b0, rd_mismatch};
  assign err_exp     = rd_mismatch ? exp_val : '1;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;
    timeout_d   = timeout_q;
    pass_d      = 1'b0;
    fail_d      = 1'b0;
    fe_addr_d   = fe_addr_q;
    fe_data_d   = fe_data_q;
    fe_exp_d    = fe_exp_q;
    run_d       = '0;
    vld_d       = vld_q;
    if (clear) begin
      state_d     = IDLE;
      rd_cnt_d    = '0;
      wr_cnt_d    = '0;
      stall_cnt_d = '0;
      err_cnt_d   = '0;
      err_flag_d  = 1'b0;
      timeout_d   = 1'b0;
      fe_addr_d   = '0;
      fe_data_d   = '0;
      fe_exp_d    = '0;
      vld_d       = '0;
    end else begin
      unique case (state_q)
        IDLE: if (enable) state_d = RUN;
        RUN: begin
          if (!enable) state_d = IDLE;
          else if (STOP_ON_ERR && (err_inc != 2'd0)) state_d = HALT;
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
      if (stall_cyc) begin
        run_d       = (run_q == RUN_TOP) ? run_q : run_q + RUN_W'(1);
        stall_cnt_d = sat_add(stall_cnt_q, 2'd1);
      end
      if (rd_commit) rd_cnt_d = sat_add(rd_cnt_q, 2'd1);
      if (wr_commit) begin
        wr_cnt_d = sat_add(wr_cnt_q, 2'd1);
        if (in_range) vld_d[idx] = 1'b1;
      end
      pass_d = rd_commit & ~rd_mismatch;
      fail_d = rd_mismatch;
      if (timeout_evt) timeout_d = 1'b1;
      if (err_inc != 2'd0) begin
        err_cnt_d  = sat_add(err_cnt_q, err_inc);
        err_flag_d = 1'b1;
        if (!err_flag_q) begin
          fe_addr_d = a_data_mem;
          fe_data_d = r_data_mem;
          fe_exp_d  = err_exp;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fe_addr_q   <= '0;
      fe_data_q   <= '0;
      fe_exp_q    <= '0;
      run_q       <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_flag_q  <= err_flag_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fe_addr_q   <= fe_addr_d;
      fe_data_q   <= fe_data_d;
      fe_exp_q    <= fe_exp_d;
      run_q       <= run_d;
      vld_q       <= vld_d;
    end
  end

  // Data array carries no reset; the valid bits alone decide whether an entry is used.
  always_ff @(posedge clk) begin
    if (wr_commit && in_range && !clear) shadow_mem[idx] <= w_data_mem;
  end

  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign stall_count    = stall_cnt_q;
  assign err_count      = err_cnt_q;
  assign err_flag       = err_flag_q;
  assign timeout        = timeout_q;
  assign chk_pass       = pass_q;
  assign chk_fail       = fail_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
  assign first_err_exp  = fe_exp_q;
  assign state          = state_q;

endmodule

// File: tb/tb_mem_txn_checker.sv
// Two monitors on one bus (8-bit counters free-running, 4-bit counters halting on error),
// compared every cycle against a transaction-level model of the checker.
module tb_mem_txn_checker;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset, enable, mode, clear, Mem_Write, Mem_read, stall;
  logic [31:0] a_data_mem, w_data_mem, r_data_mem;

  logic [7:0]  a_rd, a_wr, a_st, a_er;
  logic [3:0]  b_rd, b_wr, b_st, b_er;
  logic        a_ef, a_to, a_pass, a_fail, b_ef, b_to, b_pass, b_fail;
  logic [31:0] a_fa, a_fd, a_fe, b_fa, b_fd, b_fe;
  logic [1:0]  a_state, b_state;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_rd[2], m_wr[2], m_st[2], m_er[2], m_state[2], m_run[2];
  bit          m_ef[2], m_to[2], m_pass[2], m_fail[2];
  logic [31:0] m_fa[2], m_fd[2], m_fe[2];
  logic [31:0] m_sh[2][64];
  bit          m_vld[2][64];

  always #5 clk = ~clk;

  mem_txn_checker #(.CNT_W(8), .STALL_MAX(SMAX), .STOP_ON_ERR(1'b0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .clear(clear),
    .Mem_Write(Mem_Write), .Mem_read(Mem_read), .stall(stall),
    .a_data_mem(a_data_mem), .w_data_mem(w_data_mem), .r_data_mem(r_data_mem),
    .rd_count(a_rd), .wr_count(a_wr), .stall_count(a_st), .err_count(a_er),
    .err_flag(a_ef), .timeout(a_to), .chk_pass(a_pass), .chk_fail(a_fail),
    .first_err_addr(a_fa), .first_err_data(a_fd), .first_err_exp(a_fe), .state(a_state));

  mem_txn_checker #(.CNT_W(4), .STALL_MAX(SMAX), .STOP_ON_ERR(1'b1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .clear(clear),
    .Mem_Write(Mem_Write), .Mem_read(Mem_read), .stall(stall),
    .a_data_mem(a_data_mem), .w_data_mem(w_data_mem), .r_data_mem(r_data_mem),
    .rd_count(b_rd), .wr_count(b_wr), .stall_count(b_st), .err_count(b_er),
    .err_flag(b_ef), .timeout(b_to), .chk_pass(b_pass), .chk_fail(b_fail),
    .first_err_addr(b_fa), .first_err_data(b_fd), .first_err_exp(b_fe), .state(b_state));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] model_exp(input int k);
    logic [31:0] wa;
    wa = a_data_mem >> 2;
    if (mode && wa < 64 && m_vld[k][wa]) return m_sh[k][wa];
    return wa;
  endfunction

  task automatic model_zero(input int k);
    m_rd[k] = 0; m_wr[k] = 0; m_st[k] = 0; m_er[k] = 0; m_state[k] = 0; m_run[k] = 0;
    m_ef[k] = 0; m_to[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
    m_fa[k] = 0; m_fd[k] = 0; m_fe[k] = 0;
    for (int i = 0; i < 64; i++) m_vld[k][i] = 0;
  endtask

  task automatic model_step(input int k, input int cmax, input bit stop);
    int errs;
    logic [31:0] ex, wa;
    m_pass[k] = 0;
    m_fail[k] = 0;
    if (clear) begin
      model_zero(k);
      return;
    end
    if (m_state[k] == 0) begin
      m_run[k] = 0;
      if (enable) m_state[k] = 1;
      return;
    end
    if (m_state[k] == 2 || !enable) begin
      m_run[k] = 0;
      if (m_state[k] == 1) m_state[k] = 0;
      return;
    end
    errs = 0;
    ex = 32'hFFFF_FFFF;
    wa = a_data_mem >> 2;
    if (stall && (Mem_read || Mem_Write)) begin
      m_st[k] = sat(m_st[k] + 1, cmax);
      if (m_run[k] < SMAX) begin
        m_run[k]++;
        if (m_run[k] == SMAX) begin m_to[k] = 1; errs++; end
      end
    end else m_run[k] = 0;
    if (Mem_read && Mem_Write) errs++;
    else if (Mem_read && !stall) begin
      m_rd[k] = sat(m_rd[k] + 1, cmax);
      if (r_data_mem == model_exp(k)) m_pass[k] = 1;
      else begin m_fail[k] = 1; errs++; ex = model_exp(k); end
    end else if (Mem_Write && !stall) begin
      m_wr[k] = sat(m_wr[k] + 1, cmax);
      if (wa < 64) begin m_sh[k][wa] = w_data_mem; m_vld[k][wa] = 1; end
    end
    if (errs > 0) begin
      m_er[k] = sat(m_er[k] + errs, cmax);
      if (!m_ef[k]) begin m_fa[k] = a_data_mem; m_fd[k] = r_data_mem; m_fe[k] = ex; end
      m_ef[k] = 1;
      if (stop) m_state[k] = 2;
    end
  endtask

  task automatic cmp_dut(input int k, input string p,
                         input logic [31:0] rd, wr, st, er, input logic ef, to, ps, fl,
                         input logic [31:0] fa, fd, fe, input logic [1:0] s);
    check({p, ".rd_count"}, rd, m_rd[k]);
    check({p, ".wr_count"}, wr, m_wr[k]);
    check({p, ".stall_count"}, st, m_st[k]);
    check({p, ".err_count"}, er, m_er[k]);
    check({p, ".err_flag"}, 32'(ef), 32'(m_ef[k]));
    check({p, ".timeout"}, 32'(to), 32'(m_to[k]));
    check({p, ".chk_pass"}, 32'(ps), 32'(m_pass[k]));
    check({p, ".chk_fail"}, 32'(fl), 32'(m_fail[k]));
    check({p, ".first_err_addr"}, fa, m_fa[k]);
    check({p, ".first_err_data"}, fd, m_fd[k]);
    check({p, ".first_err_exp"}, fe, m_fe[k]);
    check({p, ".state"}, 32'(s), m_state[k]);
  endtask

  task automatic compare_all();
    cmp_dut(0, "a", 32'(a_rd), 32'(a_wr), 32'(a_st), 32'(a_er), a_ef, a_to, a_pass, a_fail,
            a_fa, a_fd, a_fe, a_state);
    cmp_dut(1, "b", 32'(b_rd), 32'(b_wr), 32'(b_st), 32'(b_er), b_ef, b_to, b_pass, b_fail,
            b_fa, b_fd, b_fe, b_state);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 255, 1'b0);
    model_step(1, 15, 1'b1);
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic drive(input bit en, input bit md, input bit cl, input bit wr, input bit rd,
                       input bit st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat);
    enable = en; mode = md; clear = cl; Mem_Write = wr; Mem_read = rd; stall = st;
    a_data_mem = a; w_data_mem = wd; r_data_mem = rdat;
  endtask

  initial begin
    int op;
    logic [31:0] addr;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_zero(0);
    model_zero(1);
    #3 compare_all();
    @(negedge clk);
    reset = 1'b1;

    // pattern read at 0x40 with two stall cycles
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 1, 32'h40, 0, 32'd16); tick(); tick();
    drive(1, 0, 0, 0, 1, 0, 32'h40, 0, 32'd16); tick();
    check("pat.chk_pass", 32'(a_pass), 1);
    check("pat.rd_count", 32'(a_rd), 1);
    check("pat.stall_count", 32'(a_st), 2);
    check("pat.err_flag", 32'(a_ef), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("pat.pulse_width", 32'(a_pass), 0);

    // shadow hit, pattern fallback, shadow mismatch
    drive(1, 1, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 0); tick();
    drive(1, 1, 0, 0, 1, 0, 32'h10, 0, 32'hDEADBEEF); tick();
    check("shd.hit_pass", 32'(a_pass), 1);
    drive(1, 1, 0, 0, 1, 0, 32'h14, 0, 32'd5); tick();
    check("shd.fallback_pass", 32'(a_pass), 1);
    drive(1, 1, 0, 0, 1, 0, 32'h10, 0, 32'd4); tick();
    check("shd.chk_fail", 32'(a_fail), 1);
    check("shd.first_err_addr", a_fa, 32'h10);
    check("shd.first_err_data", a_fd, 32'd4);
    check("shd.first_err_exp", a_fe, 32'hDEADBEEF);
    check("shd.halt_state", 32'(b_state), 2);

    // protocol error at 0x20
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 1, 0, 32'h20, 32'h55, 32'h8); tick();
    check("proto.err_count", 32'(a_er), 1);
    check("proto.rd_count", 32'(a_rd), 0);
    check("proto.wr_count", 32'(a_wr), 0);
    check("proto.first_err_exp", a_fe, 32'hFFFF_FFFF);
    check("proto.halt_state", 32'(b_state), 2);
    drive(1, 0, 0, 0, 1, 0, 32'h24, 0, 32'd9); tick(); tick();
    check("proto.halt_no_count", 32'(b_rd), 0);
    check("proto.run_counts", 32'(a_rd), 2);

    // stall timeout: ten consecutive stalled reads
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 1, 32'h30, 0, 32'd12);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == SMAX - 1) check("tmo.before", 32'(a_to), 0);
      if (i == SMAX) check("tmo.at_max", 32'(a_to), 1);
    end
    check("tmo.err_count", 32'(a_er), 1);
    check("tmo.stall_count", 32'(a_st), 10);

    // saturation, then clear racing a read commit
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 1, 0, 0, 32'(i) << 2, $urandom, 0); tick();
    end
    check("sat.wr_count_4b", 32'(b_wr), 15);
    check("sat.wr_count_8b", 32'(a_wr), 20);
    drive(1, 0, 0, 0, 1, 0, 32'h8, 0, 32'd2); tick();
    drive(1, 0, 1, 0, 1, 0, 32'h8, 0, 32'd2); tick();
    check("clr.rd_count", 32'(a_rd), 0);
    check("clr.no_pulse", 32'(a_pass), 0);
    check("clr.state", 32'(a_state), 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      op = $urandom_range(99);
      addr = ($urandom_range(99) < 90) ? (32'($urandom_range(79)) << 2) : $urandom;
      drive($urandom_range(99) < 95, 1'($urandom_range(1)), $urandom_range(99) < 2,
            op >= 40 && op < 80, op < 40 || (op >= 75 && op < 80),
            $urandom_range(99) < 20, addr, $urandom, 0);
      r_data_mem = ($urandom_range(3) != 0) ? model_exp(0) : $urandom;
      tick();
    end

    // asynchronous reset between edges
    drive(1, 0, 0, 0, 1, 0, 32'h4, 0, 32'd1); tick();
    #2 reset = 1'b0;
    model_zero(0);
    model_zero(1);
    #1 compare_all();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
